// File: rtl/sisc_fetch_unit_if.sv
// rtl/sisc_fetch_unit_if.sv - instruction-memory read handshake between fetch unit and memory
interface sisc_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - SISC instruction fetch front end (PC, IR, imem req/ack); optional timeout via SISC_FETCH_TIMEOUT_EN
module sisc_fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               fetch_go,
  input  logic               br_taken,
  input  logic               br_rel,
  input  logic [ADDR_W-1:0]  br_addr,
  sisc_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [ADDR_W-1:0]  pc,
  output logic               ir_valid,
  output logic               busy,
  output logic               halted,
  output logic               fetch_err
);

  localparam logic [ADDR_W-1:0] RESET_PC_C = RESET_PC[ADDR_W-1:0];
  localparam logic [3:0]        OP_HLT     = 4'hF;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               ir_valid_q, ir_valid_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               timeout;

`ifdef SISC_FETCH_TIMEOUT_EN
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic               fetch_err_q, fetch_err_d;
`endif

  // Branch target (relative wraps modulo 2^ADDR_W) and the address a new fetch will use
  always_comb begin
    target     = br_rel ? (pc_q + br_addr) : br_addr;
    fetch_addr = br_taken ? target : pc_q;
  end

  // Timeout fires on the 15th WAIT edge without an ack; an ack on that edge wins
  always_comb begin
`ifdef SISC_FETCH_TIMEOUT_EN
    timeout = (state_q == WAIT) && !imem.imem_ack && (wait_cnt_q == 4'd14);
`else
    timeout = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!halted_q && fetch_go) state_d = WAIT;
      WAIT: if (imem.imem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values for each state transition
  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    req_d      = req_q;
    ir_valid_d = ir_valid_q;
    busy_d     = busy_q;
    halted_d   = halted_q;
`ifdef SISC_FETCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!halted_q) begin
          if (fetch_go) begin
            addr_d     = fetch_addr;
            pc_d       = fetch_addr;
            req_d      = 1'b1;
            busy_d     = 1'b1;
            ir_valid_d = 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
            wait_cnt_d = 4'd0;
`endif
          end else if (br_taken) begin
            pc_d = target;
          end
        end
      end
      WAIT: begin
        if (imem.imem_ack) begin
          ir_d       = imem.imem_rdata;
          pc_d       = addr_q + 1'b1;
          req_d      = 1'b0;
          busy_d     = 1'b0;
          ir_valid_d = 1'b1;
          if (imem.imem_rdata[INSTR_W-1 -: 4] == OP_HLT) halted_d = 1'b1;
        end else if (timeout) begin
          ir_d        = '0;
          pc_d        = addr_q + 1'b1;
          req_d       = 1'b0;
          busy_d      = 1'b0;
          ir_valid_d  = 1'b1;
`ifdef SISC_FETCH_TIMEOUT_EN
          fetch_err_d = 1'b1;
`endif
        end else begin
`ifdef SISC_FETCH_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 4'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; asynchronous reset aborts any fetch in flight
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q       <= RESET_PC_C;
      addr_q     <= RESET_PC_C;
      ir_q       <= '0;
      req_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      req_q      <= req_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

`ifdef SISC_FETCH_TIMEOUT_EN
  // Wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wait_cnt_q  <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end
`endif

  // Output mapping
  always_comb begin
    imem.imem_req  = req_q;
    imem.imem_addr = addr_q;
    ir             = ir_q;
    opcode         = ir_q[INSTR_W-1 -: 4];
    mm             = ir_q[INSTR_W-5 -: 4];
    pc             = pc_q;
    ir_valid       = ir_valid_q;
    busy           = busy_q;
    halted         = halted_q;
`ifdef SISC_FETCH_TIMEOUT_EN
    fetch_err      = fetch_err_q;
`else
    fetch_err      = 1'b0;
`endif
  end

endmodule
